gates_vector_sequencer: RTL and testbench
=========================================

GATES_VECTOR_SEQUENCER -- requirements
Module: gates_vector_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-002 Parameter NUM_VEC, default 8: number of stored test vectors, minimum 2.
REQ-003 Parameter SETTLE, default 2: cycles that stimulus is held before the output is sampled, minimum 1.
REQ-004 Parameter CNT_W, default 4: width of the error counter.
REQ-005 Port clk  in  1  rising-edge clock.
REQ-006 Port rst  in  1  synchronous active-high reset.
REQ-007 Port start  in  1  begins a run when sampled high in IDLE.
REQ-008 Port cfg_we  in  1  vector memory write enable.
REQ-009 Port cfg_addr  in  AW=max(1,$clog2(NUM_VEC))  vector write address.
REQ-010 Port cfg_data  in  4  vector {a,b,c,expected}, with bit 3 = a.
REQ-011 Port drv  out  3  registered stimulus {a,b,c} to the gate datapath.
REQ-012 Port dut_out  in  1  gate datapath output under test.
REQ-013 Port busy  out  1  high in every state except IDLE.
REQ-014 Port done  out  1  one-cycle pulse at the end of a run.
REQ-015 Port pass  out  1  run result, valid from done until the next start.
REQ-016 Port err_count  out  CNT_W  mismatch count of the current or last run.
REQ-017 Port fail_valid  out  1  at least one mismatch occurred in the run.
REQ-018 Port first_fail  out  AW  index of the first mismatching vector.

Function
REQ-019 The vector memory (NUM_VEC x 4) SHALL be written on cfg_we when busy=0; writes while busy=1 SHALL be ignored, and reads SHALL be combinational.
REQ-020 The FSM SHALL have the states IDLE, APPLY, SETTLE, CHECK and DONE.
REQ-021 In IDLE with start=1, the FSM SHALL go to APPLY and clear idx, err_count, fail_valid, first_fail and pass.
REQ-022 In APPLY (1 cycle), the block SHALL load drv<=mem[idx][3:1] and exp<=mem[idx][0], then go to SETTLE.
REQ-023 SETTLE SHALL last exactly SETTLE cycles with drv stable, then go to CHECK.
REQ-024 In CHECK (1 cycle), the block SHALL compare dut_out with exp; on a mismatch it SHALL increment err_count, and if fail_valid=0 it SHALL set fail_valid=1 and first_fail=idx.
REQ-025 From CHECK, if idx=NUM_VEC-1 the FSM SHALL go to DONE; otherwise it SHALL set idx<=idx+1 and go to APPLY.
REQ-026 In DONE (1 cycle), the block SHALL assert done=1 and set pass=(err_count==0 and no saturation lost), then go to IDLE.
REQ-027 Each vector SHALL take SETTLE+2 cycles, and done SHALL be high exactly NUM_VEC*(SETTLE+2)+1 cycles after the clock edge that sampled start.
REQ-028 err_count SHALL saturate at 2^CNT_W-1 and SHALL never wrap; pass SHALL be 0 whenever any mismatch occurred.
REQ-029 start SHALL be ignored while busy=1, including in DONE.
REQ-030 drv, err_count, fail_valid, first_fail and pass SHALL hold their values in IDLE after a run.

Reset
REQ-031 On rst=1 the FSM SHALL enter IDLE and drv, busy, done, pass, err_count, fail_valid, first_fail, idx and exp SHALL all be 0.
REQ-032 rst SHALL take priority over start and cfg_we, and SHALL abort a run in progress in any state without asserting done.
REQ-033 Vector memory contents SHALL NOT be cleared by rst.

Structure
REQ-034 The state enum and the vector field positions (A=3, B=2, C=1, EXP=0) SHALL reside in the shared package gates_seq_pkg.
REQ-035 The vector storage SHALL be the sub-module gates_vec_mem (write port plus combinational read); the FSM and counters SHALL reside in the top module.

Verification
REQ-036 Reset: assert rst for 2 cycles -> all outputs 0, busy=0.
REQ-037 With loopback model dut_out=a^b^c, load 8 correct parity vectors, SETTLE=2, pulse start -> done exactly 33 cycles later, pass=1, err_count=0, fail_valid=0.
REQ-038 Same setup with the expected bit inverted at idx 3 and idx 6 -> err_count=2, fail_valid=1, first_fail=3, pass=0.
REQ-039 Pulse start and write cfg_we to addr 0 during the run -> a single done pulse, memory[0] unchanged, and the result identical to REQ-037.
REQ-040 Assert rst in SETTLE of idx 4 -> next cycle busy=0, drv=0, err_count=0, no done pulse; a new start then completes in 33 cycles with the REQ-037 result.
REQ-041 With CNT_W=2 and all 8 expected bits inverted -> err_count=3 (saturated), first_fail=0, pass=0.

Source files
------------

// File: rtl/gates_vector_sequencer_pkg.sv
// Shared types for the gate-vector sequencer: FSM states, vector field layout and a width helper.
package gates_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned BIT_A   = 3;
  localparam int unsigned BIT_B   = 2;
  localparam int unsigned BIT_C   = 1;
  localparam int unsigned BIT_EXP = 0;

  // Counter/address width able to index 0..n-1, never below one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gates_vector_sequencer_if.sv
// Configuration, stimulus and result bus between the sequencer and its controller.
interface gates_vector_sequencer_if
  import gates_seq_pkg::*;
#(
  parameter int unsigned NUM_VEC = 8,
  parameter int unsigned CNT_W   = 4
) ();

  localparam int unsigned AW = addr_w(NUM_VEC);

  logic             start;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [VEC_W-1:0] cfg_data;
  logic [2:0]       drv;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic             fail_valid;
  logic [AW-1:0]    first_fail;

  modport master (
    output start, cfg_we, cfg_addr, cfg_data, dut_out,
    input  drv, busy, done, pass, err_count, fail_valid, first_fail
  );

  modport slave (
    input  start, cfg_we, cfg_addr, cfg_data, dut_out,
    output drv, busy, done, pass, err_count, fail_valid, first_fail
  );

endinterface

// File: rtl/gates_vec_mem.sv
// Vector storage: synchronous write port, combinational read port, contents survive reset.
module gates_vec_mem
  import gates_seq_pkg::*;
#(
  parameter int unsigned NUM_VEC = 8,
  parameter int unsigned AW      = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [VEC_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [VEC_W-1:0] rdata
);

  logic [VEC_W-1:0] mem [NUM_VEC];

  // Out-of-range addresses only exist when NUM_VEC is not a power of two.
  if (NUM_VEC == (1 << AW)) begin : g_full
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
    end
  end else begin : g_part
    logic in_range;
    assign in_range = ({{(32 - AW){1'b0}}, waddr} < 32'(NUM_VEC));
    always_ff @(posedge clk) begin
      if (we && in_range) mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gates_vector_sequencer.sv
// Applies stored {a,b,c} vectors to a gate datapath, checks its output and reports the run result.
module gates_vector_sequencer
  import gates_seq_pkg::*;
#(
  parameter int unsigned NUM_VEC = 8,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned CNT_W   = 4
) (
  input logic                     clk,
  input logic                     rst,
  gates_vector_sequencer_if.slave bus
);

  localparam int unsigned AW = addr_w(NUM_VEC);
  localparam int unsigned SW = addr_w(SETTLE);

  state_t           state;
  logic [AW-1:0]    idx;
  logic [SW-1:0]    settle_cnt;
  logic [2:0]       drv;
  logic             exp_bit;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic             fail_valid;
  logic [AW-1:0]    first_fail;
  logic [VEC_W-1:0] rd_vec;
  logic             mem_we;

  assign mem_we = bus.cfg_we && !busy;

  gates_vec_mem #(
    .NUM_VEC (NUM_VEC),
    .AW      (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .raddr (idx),
    .rdata (rd_vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      drv        <= '0;
      exp_bit    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state      <= S_APPLY;
            busy       <= 1'b1;
            idx        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
          end
        end
        S_APPLY: begin
          drv        <= {rd_vec[BIT_A], rd_vec[BIT_B], rd_vec[BIT_C]};
          exp_bit    <= rd_vec[BIT_EXP];
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE - 1)) state <= S_CHECK;
          else settle_cnt <= settle_cnt + SW'(1);
        end
        S_CHECK: begin
          // Counter saturates; fail_valid still records that errors happened.
          if (bus.dut_out != exp_bit) begin
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              first_fail <= idx;
            end
          end
          if (idx == AW'(NUM_VEC - 1)) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + AW'(1);
            state <= S_APPLY;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          pass  <= (err_count == '0) && !fail_valid;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.drv        = drv;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.err_count  = err_count;
  assign bus.fail_valid = fail_valid;
  assign bus.first_fail = first_fail;

endmodule

// File: tb/tb_gates_vector_sequencer.sv
// Checks two sequencer instances (CNT_W=4 and CNT_W=2) sharing stimulus, with parity loopback.
module tb_gates_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [3:0] cfg_data = '0;

  always #5 clk = ~clk;

  gates_vector_sequencer_if #(.NUM_VEC(8), .CNT_W(4)) b8 ();
  gates_vector_sequencer_if #(.NUM_VEC(8), .CNT_W(2)) b2 ();

  assign b8.start    = start;
  assign b8.cfg_we   = cfg_we;
  assign b8.cfg_addr = cfg_addr;
  assign b8.cfg_data = cfg_data;
  assign b8.dut_out  = ^b8.drv;
  assign b2.start    = start;
  assign b2.cfg_we   = cfg_we;
  assign b2.cfg_addr = cfg_addr;
  assign b2.cfg_data = cfg_data;
  assign b2.dut_out  = ^b2.drv;

  gates_vector_sequencer #(.NUM_VEC(8), .SETTLE(2), .CNT_W(4)) u8 (
    .clk (clk), .rst (rst), .bus (b8.slave));
  gates_vector_sequencer #(.NUM_VEC(8), .SETTLE(2), .CNT_W(2)) u2 (
    .clk (clk), .rst (rst), .bus (b2.slave));

  int passed = 0;
  int total  = 0;
  int dn8    = 0;

  always @(negedge clk) if (b8.done) dn8++;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Vectors packed as eight nibbles, idx 0 in bits [3:0]; nibble = {a,b,c,expected}.
  task automatic load(input logic [31:0] v);
    for (int i = 0; i < 8; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = 3'(i);
      cfg_data = v[i*4 +: 4];
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  // cyc = edges after the one that sampled start, when done is first seen.
  task automatic run(input bit poke, output int cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!b8.done && cyc < 200) begin
      if (poke && cyc == 5) begin
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 4'h1; start = 1'b1;
      end else begin
        cfg_we = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    cfg_we = 1'b0;
    start  = 1'b0;
  endtask

  task automatic check_vs(input string tag, input int e8, input int e2, input int ff, input int ps);
    chk({tag, " done2"}, int'(b2.done), 1);
    chk({tag, " err8"},  int'(b8.err_count), e8);
    chk({tag, " err2"},  int'(b2.err_count), e2);
    chk({tag, " fv8"},   int'(b8.fail_valid), (e8 > 0) ? 1 : 0);
    chk({tag, " fv2"},   int'(b2.fail_valid), (e8 > 0) ? 1 : 0);
    chk({tag, " ff8"},   int'(b8.first_fail), ff);
    chk({tag, " ff2"},   int'(b2.first_fail), ff);
    chk({tag, " pass8"}, int'(b8.pass), ps);
    chk({tag, " pass2"}, int'(b2.pass), ps);
  endtask

  // Reference: a vector mismatches when its expected bit differs from a^b^c.
  function automatic void model(input logic [31:0] v, output int errs, output int ff);
    logic [3:0] n;
    errs = 0;
    ff   = 0;
    for (int i = 0; i < 8; i++) begin
      n = v[i*4 +: 4];
      if (n[0] != (n[3] ^ n[2] ^ n[1])) begin
        if (errs == 0) ff = i;
        errs++;
      end
    end
  endfunction

  typedef struct {
    string       name;
    logic [31:0] vecs;
    int          err8;
    int          err2;
    int          ff;
    int          ps;
  } vec_t;

  localparam logic [31:0] GOOD = 32'hFCA96530;

  initial begin
    vec_t tbl[5];
    int   cyc;
    int   errs;
    int   ff;
    int   d0;
    logic [31:0] v;
    logic [3:0]  nib;

    tbl[0] = '{"all_ok",   GOOD,         0, 0, 0, 1};
    tbl[1] = '{"bad_3_6",  32'hFDA97530, 2, 2, 3, 0};
    tbl[2] = '{"all_bad",  32'hEDB87421, 8, 3, 0, 0};
    tbl[3] = '{"bad_7",    32'hECA96530, 1, 1, 7, 0};
    tbl[4] = '{"bad_0",    32'hFCA96531, 1, 1, 0, 0};

    repeat (2) @(negedge clk);
    chk("rst drv",  int'(b8.drv), 0);
    chk("rst busy", int'(b8.busy), 0);
    chk("rst done", int'(b8.done), 0);
    chk("rst pass", int'(b8.pass), 0);
    chk("rst err",  int'(b8.err_count), 0);
    chk("rst fv",   int'(b8.fail_valid), 0);
    chk("rst ff",   int'(b8.first_fail), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[k]) begin
      load(tbl[k].vecs);
      run(1'b0, cyc);
      chk({tbl[k].name, " latency"}, cyc, 33);
      check_vs(tbl[k].name, tbl[k].err8, tbl[k].err2, tbl[k].ff, tbl[k].ps);
      @(negedge clk);
      chk({tbl[k].name, " done_pulse"}, int'(b8.done), 0);
      chk({tbl[k].name, " drv_hold"}, int'(b8.drv), int'(tbl[k].vecs[31:29]));
    end

    // Writes and start while busy are ignored.
    load(GOOD);
    d0 = dn8;
    run(1'b1, cyc);
    chk("poke latency", cyc, 33);
    check_vs("poke", 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    chk("poke done_count", dn8 - d0, 1);
    run(1'b0, cyc);
    check_vs("poke_mem0", 0, 0, 0, 1);
    @(negedge clk);

    // Reset mid-run, during SETTLE of idx 4.
    load(32'hFCA96520);
    d0 = dn8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort pre_err", int'(b8.err_count), 1);
    chk("abort pre_busy", int'(b8.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", int'(b8.busy), 0);
    chk("abort drv",  int'(b8.drv), 0);
    chk("abort err",  int'(b8.err_count), 0);
    repeat (20) @(negedge clk);
    chk("abort no_done", dn8 - d0, 0);
    load(GOOD);
    run(1'b0, cyc);
    chk("abort latency", cyc, 33);
    check_vs("abort_rerun", 0, 0, 0, 1);
    @(negedge clk);

    // Random vectors against the parity reference model.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 8; i++) begin
        nib[3:1] = 3'($urandom_range(0, 7));
        nib[0]   = (^nib[3:1]) ^ ($urandom_range(0, 3) == 0);
        v[i*4 +: 4] = nib;
      end
      model(v, errs, ff);
      load(v);
      run(1'b0, cyc);
      chk("rand latency", cyc, 33);
      check_vs("rand", (errs > 15) ? 15 : errs, (errs > 3) ? 3 : errs, ff, (errs == 0) ? 1 : 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
